pos_cache_reader: RTL and testbench

Read controller and streaming front end for the per-axis particle position caches (`posx`/`posy`/`posz`, single-port, 32-bit, registered output, 2-cycle read latency). On a start command it walks a contiguous, wrap-around range of cache addresses. It absorbs the RAM read latency and presents positions as a valid/ready stream to the range-limited force pipeline, with full backpressure and no data loss. One instance drives one cache; three instances in lockstep serve x/y/z.

---
 rtl/pos_cache_reader.sv | 159 +++++++++++++++
 tb/tb_pos_cache_reader.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/pos_cache_reader.sv
// pos_cache_reader: streams a wrap-around range of a position cache as valid/ready beats; define POS_READER_ABORT_EN to add an abort input
module pos_cache_reader #(
  parameter int DEPTH        = 512,
  parameter int ADDR_WIDTH   = 9,
  parameter int DATA_WIDTH   = 32,
  parameter int READ_LATENCY = 2
) (
  input  logic                  clock,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] start_addr,
  input  logic [ADDR_WIDTH:0]   num_particles,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic                  mem_rden,
  output logic                  mem_wren,
  input  logic [DATA_WIDTH-1:0] mem_q,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [ADDR_WIDTH-1:0] out_index,
  output logic                  out_valid,
  input  logic                  out_ready
`ifdef POS_READER_ABORT_EN
  ,
  input  logic                  abort
`endif
);
  localparam int FD = READ_LATENCY + 2;
  localparam int PW = $clog2(FD);
  localparam int CW = $clog2(FD + 1);
  localparam logic [ADDR_WIDTH:0]   DEPTH_W = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST_A  = ADDR_WIDTH'(DEPTH - 1);
  typedef enum logic [2:0] {IDLE, ISSUE, DRAIN, ABORT, DONE} state_t;
  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ADDR_WIDTH:0]   cnt_q, cnt_d, issued_q, issued_d, delivered_q, delivered_d;
  logic [READ_LATENCY-1:0] pv_q, pv_d;
  logic [ADDR_WIDTH-1:0] pi_q [READ_LATENCY];
  logic [ADDR_WIDTH-1:0] pi_d [READ_LATENCY];
  logic [DATA_WIDTH-1:0] fd_q [FD];
  logic [DATA_WIDTH-1:0] fd_d [FD];
  logic [ADDR_WIDTH-1:0] fi_q [FD];
  logic [ADDR_WIDTH-1:0] fi_d [FD];
  logic [PW-1:0]         wp_q, wp_d, rp_q, rp_d;
  logic [CW-1:0]         fc_q, fc_d;
  logic [CW:0]           occ;
  logic [ADDR_WIDTH:0]   clamp;
  logic                  abort_i, issue, push, pop, flush;
`ifdef POS_READER_ABORT_EN
  assign abort_i = abort && busy;
`else
  assign abort_i = 1'b0;
`endif
  assign busy        = (state_q == ISSUE) || (state_q == DRAIN) || (state_q == ABORT);
  assign done        = state_q == DONE;
  assign mem_address = addr_q;
  assign mem_rden    = issue;
  assign mem_wren    = 1'b0;
  assign out_valid   = fc_q != '0;
  assign out_data    = fd_q[rp_q];
  assign out_index   = fi_q[rp_q];
  // issue only while FIFO words plus reads still inside the RAM leave room for one more return
  always_comb begin
    occ = (CW+1)'(fc_q);
    for (int i = 0; i < READ_LATENCY; i++) occ = occ + (CW+1)'(pv_q[i]);
    clamp = (num_particles > DEPTH_W) ? DEPTH_W : num_particles;
    issue = (state_q == ISSUE) && (occ < (CW+1)'(FD)) && !abort_i;
    flush = abort_i || (state_q == ABORT);
    push  = pv_q[READ_LATENCY-1] && !flush;
    pop   = out_valid && out_ready;
  end
  // latency shadow of the RAM; an abort marks every slot busy so it doubles as the drain timer
  always_comb begin
    pv_d[0] = issue;
    pi_d[0] = addr_q;
    for (int i = 1; i < READ_LATENCY; i++) begin
      pv_d[i] = pv_q[i-1];
      pi_d[i] = pi_q[i-1];
    end
    if (abort_i) pv_d = '1;
  end
  // next state, address walk and issued/delivered bookkeeping
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    cnt_d       = cnt_q;
    issued_d    = issued_q;
    delivered_d = delivered_q;
    case (state_q)
      IDLE: if (start) begin
        state_d     = (clamp == '0) ? DONE : ISSUE;
        addr_d      = start_addr;
        cnt_d       = clamp;
        issued_d    = '0;
        delivered_d = '0;
      end
      ISSUE: state_d = abort_i ? ABORT : (issue && issued_q + 1'b1 == cnt_q) ? DRAIN : ISSUE;
      DRAIN: state_d = abort_i ? ABORT : (pop && delivered_q + 1'b1 == cnt_q) ? DONE : DRAIN;
      ABORT: state_d = (pv_d == '0) ? DONE : ABORT;
      default: state_d = IDLE;
    endcase
    if (issue) begin
      addr_d   = (addr_q == LAST_A) ? '0 : addr_q + 1'b1;
      issued_d = issued_q + 1'b1;
    end
    if (pop) delivered_d = delivered_q + 1'b1;
  end
  // output FIFO: write returning words, read head is the stream output, abort empties it
  always_comb begin
    fd_d = fd_q;
    fi_d = fi_q;
    wp_d = wp_q;
    rp_d = rp_q;
    fc_d = fc_q + CW'(push) - CW'(pop);
    if (push) begin
      fd_d[wp_q] = mem_q;
      fi_d[wp_q] = pi_q[READ_LATENCY-1];
      wp_d       = (wp_q == PW'(FD - 1)) ? '0 : wp_q + 1'b1;
    end
    if (pop) rp_d = (rp_q == PW'(FD - 1)) ? '0 : rp_q + 1'b1;
    if (flush) begin
      wp_d = '0;
      rp_d = '0;
      fc_d = '0;
    end
  end
  // all state registers; reset clears FIFO contents so the stream outputs read back as zero
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      cnt_q       <= '0;
      issued_q    <= '0;
      delivered_q <= '0;
      pv_q        <= '0;
      wp_q        <= '0;
      rp_q        <= '0;
      fc_q        <= '0;
      for (int i = 0; i < READ_LATENCY; i++) pi_q[i] <= '0;
      for (int i = 0; i < FD; i++) begin
        fd_q[i] <= '0;
        fi_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      cnt_q       <= cnt_d;
      issued_q    <= issued_d;
      delivered_q <= delivered_d;
      pv_q        <= pv_d;
      pi_q        <= pi_d;
      wp_q        <= wp_d;
      rp_q        <= rp_d;
      fc_q        <= fc_d;
      fd_q        <= fd_d;
      fi_q        <= fi_d;
    end
  end
endmodule

// File: tb/tb_pos_cache_reader.sv
// tb_pos_cache_reader: directed checks of pos_cache_reader against a 2-cycle RAM model
module tb_pos_cache_reader;
  localparam int AW = 9;
  localparam int DW = 32;
  logic clock = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic out_ready = 1'b1;
  logic [AW-1:0] start_addr = '0;
  logic [AW:0] num_particles = '0;
  logic busy, done, mem_rden, mem_wren, out_valid;
  logic [AW-1:0] mem_address, out_index;
  logic [DW-1:0] mem_q, out_data, ram_s1;
`ifdef POS_READER_ABORT_EN
  logic abort = 1'b0;
`endif
  int checks = 0;
  int passes = 0;
  int cyc = 0;
  int t0 = 0;
  int n_rden, n_beat, done_cyc, max_out, unstable, busy_seen, busy_at_done;
  int done_with_valid = 0;
  logic [AW-1:0] rd_addr[$];
  logic [AW-1:0] beat_idx[$];
  logic [DW-1:0] beat_dat[$];
  int beat_cyc[$];
  logic prev_stall;
  logic [DW-1:0] prev_data;
  logic [AW-1:0] prev_idx;
  logic rmode = 1'b0;
  logic [3:0] pat = 4'b1001;
  pos_cache_reader dut (
    .clock(clock), .rst_n(rst_n), .start(start), .start_addr(start_addr),
    .num_particles(num_particles), .busy(busy), .done(done),
    .mem_address(mem_address), .mem_rden(mem_rden), .mem_wren(mem_wren), .mem_q(mem_q),
    .out_data(out_data), .out_index(out_index), .out_valid(out_valid), .out_ready(out_ready)
`ifdef POS_READER_ABORT_EN
    , .abort(abort)
`endif
  );
  always #5 clock = ~clock;
  // cycle counter used to time events relative to start
  always @(posedge clock) cyc <= cyc + 1;
  function automatic logic [DW-1:0] word(input logic [AW-1:0] a);
    return {16'hC0DE, 7'd0, a};
  endfunction
  // cache model: registered output two cycles after rden
  always @(posedge clock) begin
    if (mem_rden) ram_s1 <= word(mem_address);
    mem_q <= ram_s1;
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask
  initial forever begin
    @(posedge clock);
    #1;
    out_ready = rmode ? pat[cyc % 4] : 1'b1;
  end
  initial forever begin
    @(negedge clock);
    if (rst_n) begin
      if (mem_rden) begin
        n_rden++;
        rd_addr.push_back(mem_address);
      end
      if (n_rden - n_beat > max_out) max_out = n_rden - n_beat;
      if (prev_stall && (out_data !== prev_data || out_index !== prev_idx || !out_valid)) unstable++;
      if (out_valid && out_ready) begin
        n_beat++;
        beat_idx.push_back(out_index);
        beat_dat.push_back(out_data);
        beat_cyc.push_back(cyc - t0);
      end
      if (busy) busy_seen = 1;
      if (done && done_cyc < 0) begin
        done_cyc = cyc - t0;
        busy_at_done = 32'(busy);
      end
      if (done && out_valid) done_with_valid++;
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      prev_idx   = out_index;
    end
  end
  task automatic launch(input logic [AW-1:0] a, input logic [AW:0] n);
    @(posedge clock);
    #1;
    n_rden = 0; n_beat = 0; done_cyc = -1; max_out = 0; unstable = 0;
    busy_seen = 0; busy_at_done = -1; prev_stall = 1'b0;
    rd_addr.delete(); beat_idx.delete(); beat_dat.delete(); beat_cyc.delete();
    start = 1'b1; start_addr = a; num_particles = n; t0 = cyc;
    @(posedge clock);
    #1;
    start = 1'b0;
  endtask
  task automatic wait_done(input int lim);
    int k = 0;
    while (done_cyc < 0 && k < lim) begin
      @(negedge clock);
      k++;
    end
    #1;
    check("done_seen", 32'(done_cyc >= 0), 1);
    repeat (2) @(posedge clock);
  endtask
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    repeat (3) @(posedge clock);
    #1;
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_valid", 32'(out_valid), 0);
    check("rst_rden", 32'(mem_rden), 0);
    check("rst_wren", 32'(mem_wren), 0);
    check("rst_addr", 32'(mem_address), 0);
    check("rst_data", out_data, 0);
    check("rst_index", 32'(out_index), 0);
    rst_n = 1'b1;
    launch(0, 8);
    @(negedge clock);
    check("c1_busy", 32'(busy), 1);
    check("c1_rden", 32'(mem_rden), 1);
    check("c1_addr", 32'(mem_address), 0);
    wait_done(40);
    check("t1_beats", n_beat, 8);
    check("t1_rden", n_rden, 8);
    check("t1_done_cyc", done_cyc, 12);
    check("t1_busy_at_done", busy_at_done, 0);
    for (int i = 0; i < 8; i++) begin
      check("t1_idx", 32'(beat_idx[i]), i);
      check("t1_dat", beat_dat[i], word(AW'(i)));
      check("t1_cyc", beat_cyc[i], 4 + i);
    end
    launch(510, 4);
    wait_done(40);
    check("t2_rden", n_rden, 4);
    check("t2_beats", n_beat, 4);
    for (int i = 0; i < 4; i++) begin
      check("t2_addr", 32'(rd_addr[i]), (510 + i) % 512);
      check("t2_idx", 32'(beat_idx[i]), (510 + i) % 512);
      check("t2_dat", beat_dat[i], word(AW'((510 + i) % 512)));
    end
    rmode = 1'b1;
    launch(100, 16);
    wait_done(200);
    rmode = 1'b0;
    check("t3_beats", n_beat, 16);
    check("t3_rden", n_rden, 16);
    check("t3_outstanding_le4", 32'(max_out <= 4), 1);
    check("t3_stall_stable", unstable, 0);
    for (int i = 0; i < 16; i++) begin
      check("t3_idx", 32'(beat_idx[i]), 100 + i);
      check("t3_dat", beat_dat[i], word(AW'(100 + i)));
    end
    launch(0, 0);
    wait_done(10);
    check("t4_zero_done_cyc", done_cyc, 1);
    check("t4_zero_rden", n_rden, 0);
    check("t4_zero_busy", busy_seen, 0);
    launch(0, 600);
    wait_done(560);
    check("t4_clamp_beats", n_beat, 512);
    check("t4_clamp_rden", n_rden, 512);
    check("t4_clamp_done_cyc", done_cyc, 516);
    check("t4_clamp_first", 32'(beat_idx[0]), 0);
    check("t4_clamp_last", 32'(beat_idx[511]), 511);
    launch(0, 8);
    @(posedge clock); #1;
    @(posedge clock); #1;
    start = 1'b1; start_addr = 300; num_particles = 2;
    @(posedge clock); #1;
    start = 1'b0;
    wait_done(40);
    check("t5_beats", n_beat, 8);
    check("t5_done_cyc", done_cyc, 12);
    check("t5_last_idx", 32'(beat_idx[7]), 7);
    launch(0, 8);
    repeat (4) begin
      @(posedge clock);
      #1;
    end
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", 32'(busy), 0);
    check("mid_rst_valid", 32'(out_valid), 0);
    check("mid_rst_rden", 32'(mem_rden), 0);
    check("mid_rst_addr", 32'(mem_address), 0);
    check("mid_rst_data", out_data, 0);
    check("mid_rst_index", 32'(out_index), 0);
    @(posedge clock);
    #1;
    rst_n = 1'b1;
    launch(20, 3);
    wait_done(20);
    check("t6_beats", n_beat, 3);
    check("t6_done_cyc", done_cyc, 7);
    for (int i = 0; i < 3; i++) check("t6_idx", 32'(beat_idx[i]), 20 + i);
`ifdef POS_READER_ABORT_EN
    launch(0, 32);
    repeat (5) begin
      @(posedge clock);
      #1;
    end
    abort = 1'b1;
    @(posedge clock);
    #1;
    abort = 1'b0;
    @(negedge clock);
    check("ab_valid_c7", 32'(out_valid), 0);
    @(negedge clock);
    check("ab_valid_c8", 32'(out_valid), 0);
    wait_done(20);
    check("ab_done_cyc", done_cyc, 9);
    check("ab_rden", n_rden, 5);
    check("ab_beats", n_beat, 3);
`endif
    check("done_vs_valid", done_with_valid, 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
